basic_io_irq_b3: RTL

//   Parametrised successor of the Basys3 on-board I/O register block. It serves switches, buttons,

---
 rtl/basic_io_pkg.sv | 48 ++++
 rtl/debounce_b3.sv | 51 +++++
 rtl/display_io_b3.sv | 45 ++++
 rtl/basic_io_irq_b3.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/basic_io_pkg.sv
// Shared definitions for the Basys3 I/O register block.
// Holds the register map, the blank-digit code and the hex-to-segment decoder
// used by the display driver. No ports (package).
package basic_io_pkg;

  localparam logic [7:0] ADDR_SW_LO  = 8'h00;
  localparam logic [7:0] ADDR_SW_HI  = 8'h01;
  localparam logic [7:0] ADDR_BTN    = 8'h02;
  localparam logic [7:0] ADDR_PEND   = 8'h03;
  localparam logic [7:0] ADDR_LED_LO = 8'h04;
  localparam logic [7:0] ADDR_LED_HI = 8'h05;
  localparam logic [7:0] ADDR_DP     = 8'h06;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h07;
  localparam logic [7:0] ADDR_CTRL   = 8'h0b;
  localparam logic [7:0] ADDR_DIG0   = 8'h0c;

  // Bit 4 of a digit register marks the digit as blank.
  localparam logic [7:0] DIGIT_BLANK = 8'h10;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [7:0] digit);
    logic [6:0] s;
    if (digit[4]) begin
      s = 7'b1111111;
    end else begin
      case (digit[3:0])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'ha: s = 7'b0001000;
        4'hb: s = 7'b0000011;
        4'hc: s = 7'b1000110;
        4'hd: s = 7'b0100001;
        4'he: s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/debounce_b3.sv
// One-bit input conditioner: 2-flop synchronizer followed by a stability counter.
// Ports: clk, reset (sync, active-high), raw (asynchronous input),
//        level (debounced value), rise (one-cycle pulse on the clk edge where
//        level flips 0->1, asserted combinationally in the cycle before that edge).
module debounce_b3 #(
  parameter int DB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;
  logic            flip;

  // The level flips on the edge where a disagreeing input has already been
  // seen for DB_CYCLES-1 counted cycles; rise lets the caller latch the event
  // on that very same edge.
  assign flip = (sync2 != level) && (cnt == CNT_LAST);
  assign rise = flip && sync2;

  // Synchronizer and counter are cleared by reset too, so a held input is
  // re-detected from scratch afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_io_b3.sv
// Multiplexed 4-digit 7-segment driver.
// Ports: clk, reset (sync, active-high), enable (display on), digits (4 x 8-bit
//        digit codes, digit 0 in bits [7:0]), dp_buf (one decimal point per digit),
//        seg (active-low segments), dp (active-low point), an (active-low digit select).
module display_io_b3
  import basic_io_pkg::*;
#(
  parameter int REFRESH_W = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] digits,
  input  logic [3:0]  dp_buf,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic [REFRESH_W-1:0] refresh;
  logic [1:0]           sel;
  logic [7:0]           cur;

  always_ff @(posedge clk) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + 1'b1;
  end

  // The top two refresh bits pick the digit, giving a slow round-robin scan.
  assign sel = refresh[REFRESH_W-1 -: 2];
  assign cur = digits[{sel, 3'b000} +: 8];

  // Everything is dark while the display is disabled.
  always_comb begin
    seg = 7'b1111111;
    dp  = 1'b1;
    an  = 4'b1111;
    if (enable) begin
      seg = hex_to_seg(cur);
      dp  = ~dp_buf[sel];
      an  = ~(4'b0001 << sel);
    end
  end

endmodule

// File: rtl/basic_io_irq_b3.sv
// Basys3 on-board I/O register block on the 8-bit CPU bus, with debounced
// switches/buttons, latched button-press events (write-1-to-clear) and a
// maskable level interrupt.
// Ports: clk, reset (sync, active-high), addr/data_in/data_out/re/we (CPU bus,
//        combinational read), sw/btn (raw inputs), led, seg/dp/an (display), irq.
module basic_io_irq_b3
  import basic_io_pkg::*;
#(
  parameter int SW_W      = 16,
  parameter int BTN_N     = 5,
  parameter int LED_W     = 16,
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  input  logic             re,
  input  logic             we,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_N-1:0] btn,
  output logic [LED_W-1:0] led,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic             irq
);

  localparam logic [15:0] LED_MASK = 16'((32'd1 << LED_W) - 1);

  logic [SW_W+BTN_N-1:0] raw_in;
  logic [SW_W+BTN_N-1:0] lvl;
  logic [SW_W+BTN_N-1:0] rise_v;
  logic [BTN_N-1:0]      btn_rise;
  logic                  unused_sw_rise;

  logic [15:0]      led_r;
  logic [3:0]       dp_buf;
  logic             ctrl_r;
  logic [BTN_N-1:0] irq_en;
  logic [BTN_N-1:0] btn_pend;
  logic [BTN_N-1:0] pend_clr;
  logic [3:0][7:0]  digit_r;
  logic [3:0][7:0]  digits_disp;
  logic             irq_r;

  logic [15:0] sw16;
  logic [7:0]  btn8;
  logic [7:0]  pend8;
  logic [7:0]  en8;

  // Switches occupy the low debouncer slots, buttons the high ones.
  assign raw_in = {btn, sw};

  for (genvar i = 0; i < SW_W + BTN_N; i++) begin : g_db
    debounce_b3 #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[i]),
      .level (lvl[i]),
      .rise  (rise_v[i])
    );
  end

  assign btn_rise       = rise_v[SW_W +: BTN_N];
  assign unused_sw_rise = ^rise_v[SW_W-1:0];

  // W1C mask for the pending register; only a write to the pend address clears.
  always_comb begin
    pend_clr = '0;
    if (we && addr == ADDR_PEND) pend_clr = data_in[BTN_N-1:0];
  end

  // Register file. New press events are OR'd in after the clear so a set and a
  // clear on the same edge leave the bit set. irq samples the pre-edge pend/en,
  // which is what makes it lag one cycle behind them.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r    <= '0;
      dp_buf   <= '0;
      ctrl_r   <= 1'b0;
      irq_en   <= '0;
      btn_pend <= '0;
      digit_r  <= {4{DIGIT_BLANK}};
      irq_r    <= 1'b0;
    end else begin
      btn_pend <= (btn_pend & ~pend_clr) | btn_rise;
      irq_r    <= |(btn_pend & irq_en);
      if (we) begin
        case (addr)
          ADDR_LED_LO: led_r[7:0]  <= data_in & LED_MASK[7:0];
          ADDR_LED_HI: led_r[15:8] <= data_in & LED_MASK[15:8];
          ADDR_DP:     dp_buf      <= data_in[3:0];
          ADDR_IRQ_EN: irq_en      <= data_in[BTN_N-1:0];
          ADDR_CTRL:   ctrl_r      <= data_in[0];
          default: ;
        endcase
        for (int d = 0; d < DIGITS; d++) begin
          if (addr == ADDR_DIG0 + 8'(d)) digit_r[d] <= data_in;
        end
      end
    end
  end

  // Zero-extended views so narrow parameterisations read 0 in unused bits.
  always_comb begin
    sw16  = '0;
    btn8  = '0;
    pend8 = '0;
    en8   = '0;
    sw16[SW_W-1:0]   = lvl[SW_W-1:0];
    btn8[BTN_N-1:0]  = lvl[SW_W +: BTN_N];
    pend8[BTN_N-1:0] = btn_pend;
    en8[BTN_N-1:0]   = irq_en;
  end

  // Reads are purely combinational and side-effect free.
  always_comb begin
    data_out = '0;
    if (re) begin
      case (addr)
        ADDR_SW_LO:  data_out = sw16[7:0];
        ADDR_SW_HI:  data_out = sw16[15:8];
        ADDR_BTN:    data_out = btn8;
        ADDR_PEND:   data_out = pend8;
        ADDR_LED_LO: data_out = led_r[7:0];
        ADDR_LED_HI: data_out = led_r[15:8];
        ADDR_DP:     data_out = {4'b0000, dp_buf};
        ADDR_IRQ_EN: data_out = en8;
        ADDR_CTRL:   data_out = {7'b0000000, ctrl_r};
        default: begin
          for (int d = 0; d < DIGITS; d++) begin
            if (addr == ADDR_DIG0 + 8'(d)) data_out = digit_r[d];
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      digits_disp[d] = (d < DIGITS) ? digit_r[d] : DIGIT_BLANK;
    end
  end

  display_io_b3 u_disp (
    .clk    (clk),
    .reset  (reset),
    .enable (ctrl_r),
    .digits (digits_disp),
    .dp_buf (dp_buf),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  assign led = led_r[LED_W-1:0];
  assign irq = irq_r;

endmodule
